// File: rtl/clock_scaler_multi.sv
// Multi-channel programmable clock divider: each channel produces a 50% toggled
// clock or a one-cycle strobe from clock_in, with double-buffered factor reloads.
module clock_scaler_multi #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 30,
    parameter int DEFAULT_FACTOR = 1
) (
    input  logic                      clock_in,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       run_flag,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*WIDTH-1:0] scaling_factor,
    input  logic [CHANNELS-1:0]       load,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clock_out,
    output logic [CHANNELS-1:0]       tick
);

    localparam logic [WIDTH-1:0] DEFAULT_C = WIDTH'(DEFAULT_FACTOR);
    localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};

    logic [WIDTH-1:0]    count_r  [CHANNELS];
    logic [WIDTH-1:0]    shadow_r [CHANNELS];
    logic [WIDTH-1:0]    active_r [CHANNELS];
    logic [WIDTH-1:0]    last_s   [CHANNELS];
    logic [CHANNELS-1:0] clock_out_r;
    logic [CHANNELS-1:0] tick_r;
    logic [CHANNELS-1:0] tc_s;

    // Terminal-count detect; an active factor of 0 behaves as 1 so the channel never locks up
    always_comb begin
        tc_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            last_s[i] = ZERO_C;
            if (active_r[i] == ZERO_C) begin
                last_s[i] = ZERO_C;
            end else begin
                last_s[i] = active_r[i] - ONE_C;
            end
            tc_s[i] = run_flag[i] & (count_r[i] == last_s[i]);
        end
    end

    // Per-channel counter, factor buffering and output state, in idle > sync > TC > count priority
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_r[i]  <= ZERO_C;
                shadow_r[i] <= DEFAULT_C;
                active_r[i] <= DEFAULT_C;
            end
            clock_out_r <= {CHANNELS{1'b0}};
            tick_r      <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (load[i]) begin
                    shadow_r[i] <= scaling_factor[i*WIDTH +: WIDTH];
                end
                if (!run_flag[i]) begin
                    count_r[i]     <= ZERO_C;
                    clock_out_r[i] <= 1'b0;
                    tick_r[i]      <= 1'b0;
                    active_r[i]    <= shadow_r[i];
                end else if (sync) begin
                    count_r[i]     <= ZERO_C;
                    clock_out_r[i] <= 1'b0;
                    tick_r[i]      <= 1'b0;
                end else if (tc_s[i]) begin
                    // active takes the pre-edge shadow, so a load on this edge waits one period
                    count_r[i]     <= ZERO_C;
                    tick_r[i]      <= 1'b1;
                    active_r[i]    <= shadow_r[i];
                    clock_out_r[i] <= mode[i] ? 1'b1 : ~clock_out_r[i];
                end else begin
                    count_r[i]     <= count_r[i] + ONE_C;
                    tick_r[i]      <= 1'b0;
                    clock_out_r[i] <= mode[i] ? 1'b0 : clock_out_r[i];
                end
            end
        end
    end

    assign clock_out = clock_out_r;
    assign tick      = tick_r;

endmodule
